mac_job_scheduler: RTL and testbench

//  Round-robin scheduler that shares one 4-stage signed MAC pipeline (op/a/b/acc -> q) between
//  N_CH requesters. Each granted job computes res = (bias + sum_k coef[k]*samp[ch][k]) >>> SHIFT.

---
 rtl/mac_sched_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 59 +++++
 rtl/mac_job_scheduler.sv | 159 +++++++++++++++
 tb/tb_mac_job_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_sched_pkg.sv
// Shared op-codes, FSM state type and datapath widths for the MAC job scheduler.
package mac_sched_pkg;

    localparam int MAC_A_W   = 32;
    localparam int MAC_ACC_W = 64;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MAC   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_TRUNC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer moves past it on advance.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         req_i,
    input  logic                 adv_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW:0]   scan;
    logic [IW-1:0] cand;
    logic          found;

    assign any_o = |req_i;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        scan  = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            scan = {1'b0, ptr_q} + (IW+1)'(i);
            if (scan >= (IW+1)'(N)) begin
                scan = scan - (IW+1)'(N);
            end
            cand = scan[IW-1:0];
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = (idx_o == IW'(N-1)) ? '0 : idx_o + IW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mac_job_scheduler.sv
// Shares one pipelined signed MAC between N_CH requesters, one job at a time, round-robin.
//   state    | meaning
//   ST_IDLE  | waiting for a request; grant taken here
//   ST_LOAD  | bias loaded into the MAC, tap 0 addressed
//   ST_RUN   | one MAC per tap, next tap addressed
//   ST_DRAIN | wait for the MAC pipeline, capture result on last cycle
module mac_job_scheduler
    import mac_sched_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int N_TAPS      = 8,
    parameter int MAC_LATENCY = 4,
    parameter int SHIFT       = 0
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic [N_CH-1:0]                              req_i,
    input  logic [MAC_ACC_W*N_CH-1:0]                    bias_i,
    output logic                                         busy_o,
    output logic [((N_TAPS > 1) ? $clog2(N_TAPS) : 1)-1:0] coef_addr_o,
    output logic [$clog2(N_CH)+((N_TAPS > 1) ? $clog2(N_TAPS) : 1)-1:0] samp_addr_o,
    input  logic [MAC_A_W-1:0]                           coef_data_i,
    input  logic [MAC_A_W-1:0]                           samp_data_i,
    output logic [1:0]                                   mac_op_o,
    output logic [MAC_A_W-1:0]                           mac_a_o,
    output logic [MAC_A_W-1:0]                           mac_b_o,
    output logic [MAC_ACC_W-1:0]                         mac_acc_o,
    input  logic [MAC_ACC_W-1:0]                         mac_q_i,
    output logic                                         res_valid_o,
    output logic [$clog2(N_CH)-1:0]                      res_ch_o,
    output logic [MAC_ACC_W-1:0]                         res_data_o,
    output logic [N_CH-1:0]                              ack_o
);

    localparam int CH_W  = $clog2(N_CH);
    localparam int TAP_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam int CNT_MAX = (N_TAPS > MAC_LATENCY) ? N_TAPS : MAC_LATENCY;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    state_t                 state_q, state_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [N_CH-1:0]        gnt_q, gnt_d;
    logic [TAP_W-1:0]       tap_q, tap_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   res_valid_q, res_valid_d;
    logic [N_CH-1:0]        ack_q, ack_d;
    logic [CH_W-1:0]        res_ch_q, res_ch_d;
    logic [MAC_ACC_W-1:0]   res_data_q, res_data_d;

    logic                   arb_adv;
    logic [N_CH-1:0]        arb_gnt;
    logic [CH_W-1:0]        arb_idx;
    logic                   arb_any;

    rr_arbiter #(.N(N_CH)) u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req_i),
        .adv_i (arb_adv),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        gnt_d       = gnt_q;
        tap_d       = tap_q;
        cnt_d       = cnt_q;
        res_valid_d = 1'b0;
        ack_d       = '0;
        res_ch_d    = res_ch_q;
        res_data_d  = res_data_q;
        arb_adv     = 1'b0;
        mac_op_o    = OP_MUL;
        mac_a_o     = '0;
        mac_b_o     = '0;
        mac_acc_o   = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    arb_adv = 1'b1;
                    ch_d    = arb_idx;
                    gnt_d   = arb_gnt;
                    tap_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mac_op_o  = OP_LOAD;
                mac_acc_o = bias_i[MAC_ACC_W*ch_q +: MAC_ACC_W];
                tap_d     = (N_TAPS > 1) ? TAP_W'(1) : '0;
                cnt_d     = CNT_W'(N_TAPS - 1);
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                mac_op_o = OP_MAC;
                mac_a_o  = coef_data_i;
                mac_b_o  = samp_data_i;
                // address runs one tap ahead of the data, parking on the last tap
                if (tap_q != TAP_W'(N_TAPS - 1)) begin
                    tap_d = tap_q + TAP_W'(1);
                end
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(MAC_LATENCY - 1);
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    res_valid_d = 1'b1;
                    ack_d       = gnt_q;
                    res_ch_d    = ch_q;
                    res_data_d  = MAC_ACC_W'($signed(mac_q_i) >>> SHIFT);
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            gnt_q       <= '0;
            tap_q       <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            ack_q       <= '0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            gnt_q       <= gnt_d;
            tap_q       <= tap_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            ack_q       <= ack_d;
            res_ch_q    <= res_ch_d;
            res_data_q  <= res_data_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign coef_addr_o = tap_q;
    assign samp_addr_o = {ch_q, tap_q};
    assign res_valid_o = res_valid_q;
    assign ack_o       = ack_q;
    assign res_ch_o    = res_ch_q;
    assign res_data_o  = res_data_q;

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Bench for mac_job_scheduler: registered RAMs, 4-stage MAC model, job-level golden results.
module tb_mac_job_scheduler;
    import mac_sched_pkg::*;

    localparam int N_CH        = 4;
    localparam int N_TAPS      = 8;
    localparam int MAC_LATENCY = 4;
    localparam int SHIFT       = 2;
    localparam int JOB_LEN     = N_TAPS + MAC_LATENCY + 2;
    localparam int CH_W        = 2;
    localparam int TAP_W       = 3;

    logic                    clk_i = 1'b0;
    logic                    rst_i = 1'b1;
    logic [N_CH-1:0]         req_i = '0;
    logic [64*N_CH-1:0]      bias_i;
    logic                    busy_o;
    logic [TAP_W-1:0]        coef_addr_o;
    logic [CH_W+TAP_W-1:0]   samp_addr_o;
    logic [31:0]             coef_data_i;
    logic [31:0]             samp_data_i;
    logic [1:0]              mac_op_o;
    logic [31:0]             mac_a_o;
    logic [31:0]             mac_b_o;
    logic [63:0]             mac_acc_o;
    logic [63:0]             mac_q_i;
    logic                    res_valid_o;
    logic [CH_W-1:0]         res_ch_o;
    logic [63:0]             res_data_o;
    logic [N_CH-1:0]         ack_o;

    int     coef_mem [N_TAPS];
    int     samp_mem [N_CH*N_TAPS];
    longint bias_mem [N_CH];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int ptr_m       = 0;

    mac_job_scheduler #(
        .N_CH(N_CH), .N_TAPS(N_TAPS), .MAC_LATENCY(MAC_LATENCY), .SHIFT(SHIFT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .bias_i(bias_i), .busy_o(busy_o),
        .coef_addr_o(coef_addr_o), .samp_addr_o(samp_addr_o),
        .coef_data_i(coef_data_i), .samp_data_i(samp_data_i),
        .mac_op_o(mac_op_o), .mac_a_o(mac_a_o), .mac_b_o(mac_b_o), .mac_acc_o(mac_acc_o),
        .mac_q_i(mac_q_i), .res_valid_o(res_valid_o), .res_ch_o(res_ch_o),
        .res_data_o(res_data_o), .ack_o(ack_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        bias_i = '0;
        for (int c = 0; c < N_CH; c++) bias_i[64*c +: 64] = bias_mem[c];
    end

    always @(posedge clk_i) begin
        coef_data_i <= coef_mem[coef_addr_o];
        samp_data_i <= samp_mem[samp_addr_o];
    end

    // MAC: operands travel MAC_LATENCY-1 stages, the last stage updates q
    logic [1:0]  p_op  [MAC_LATENCY-1];
    logic [31:0] p_a   [MAC_LATENCY-1];
    logic [31:0] p_b   [MAC_LATENCY-1];
    logic [63:0] p_acc [MAC_LATENCY-1];

    function automatic longint prod(input logic [31:0] a, input logic [31:0] b);
        return longint'($signed(a)) * longint'($signed(b));
    endfunction

    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAC_LATENCY-1; i++) begin
                p_op[i] <= OP_MUL; p_a[i] <= '0; p_b[i] <= '0; p_acc[i] <= '0;
            end
            mac_q_i <= '0;
        end else begin
            p_op[0] <= mac_op_o; p_a[0] <= mac_a_o; p_b[0] <= mac_b_o; p_acc[0] <= mac_acc_o;
            for (int i = 1; i < MAC_LATENCY-1; i++) begin
                p_op[i] <= p_op[i-1]; p_a[i] <= p_a[i-1]; p_b[i] <= p_b[i-1]; p_acc[i] <= p_acc[i-1];
            end
            case (p_op[MAC_LATENCY-2])
                OP_MUL:  mac_q_i <= prod(p_a[MAC_LATENCY-2], p_b[MAC_LATENCY-2]);
                OP_MAC:  mac_q_i <= mac_q_i + prod(p_a[MAC_LATENCY-2], p_b[MAC_LATENCY-2]);
                OP_LOAD: mac_q_i <= p_acc[MAC_LATENCY-2];
                default: mac_q_i <= mac_q_i;
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
    endtask

    function automatic int rr_pick(input logic [N_CH-1:0] m, input int p);
        for (int i = 0; i < N_CH; i++) begin
            if (m[(p + i) % N_CH]) return (p + i) % N_CH;
        end
        return -1;
    endfunction

    function automatic longint golden(input int ch);
        longint acc;
        acc = bias_mem[ch];
        for (int k = 0; k < N_TAPS; k++)
            acc += longint'(coef_mem[k]) * longint'(samp_mem[ch*N_TAPS + k]);
        return acc >>> SHIFT;
    endfunction

    task automatic clear_mems();
        for (int k = 0; k < N_TAPS; k++) coef_mem[k] = 0;
        for (int k = 0; k < N_CH*N_TAPS; k++) samp_mem[k] = 0;
        for (int c = 0; c < N_CH; c++) bias_mem[c] = 0;
    endtask

    task automatic rand_mems();
        for (int k = 0; k < N_TAPS; k++) coef_mem[k] = int'($urandom);
        for (int k = 0; k < N_CH*N_TAPS; k++) samp_mem[k] = int'($urandom);
        for (int c = 0; c < N_CH; c++) bias_mem[c] = {$urandom, $urandom};
    endtask

    // mask is held for njobs results, then released on the last strobe
    task automatic run_jobs(input logic [N_CH-1:0] mask, input int njobs, input bit drop_early);
        int t0, n, ch;
        longint exp_d;
        logic [N_CH-1:0] exp_ack;
        exp_d = 0;
        req_i = mask;
        t0    = cyc;
        for (int j = 0; j < njobs; j++) begin
            ch      = rr_pick(mask, ptr_m);
            ptr_m   = (ch + 1) % N_CH;
            exp_d   = golden(ch);
            exp_ack = '0;
            exp_ack[ch] = 1'b1;
            if (drop_early) begin
                tick();
                check("busy_after_grant", 64'(busy_o), 64'd1);
                tick();
                req_i = '0;
            end
            n = 0;
            do begin
                tick();
                n++;
            end while (!res_valid_o && n < 4*JOB_LEN);
            check("strobe_seen", 64'(res_valid_o), 64'd1);
            check("latency", 64'(cyc - t0), 64'(JOB_LEN));
            check("res_ch", 64'(res_ch_o), 64'(ch));
            check("res_data", res_data_o, exp_d);
            check("ack", 64'(ack_o), 64'(exp_ack));
            t0 = cyc;
            if (j == njobs - 1) req_i = '0;
        end
        repeat (3) tick();
        check("hold_data", res_data_o, exp_d);
        check("idle_after", 64'({res_valid_o, busy_o, ack_o}), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int strobes;
        clear_mems();
        rst_i = 1'b1;
        req_i = '0;
        repeat (3) tick();
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_valid", 64'(res_valid_o), 64'd0);
        check("rst_ack", 64'(ack_o), 64'd0);
        check("rst_data", res_data_o, 64'd0);
        check("rst_ch", 64'(res_ch_o), 64'd0);
        check("rst_addr", 64'({coef_addr_o, samp_addr_o}), 64'd0);
        check("rst_op", 64'({mac_op_o, mac_a_o, mac_b_o}), 64'd0);
        rst_i = 1'b0;
        tick();

        // 4 non-zero taps, request dropped right after grant
        coef_mem[0] = 1; coef_mem[1] = 2; coef_mem[2] = 3; coef_mem[3] = 4;
        samp_mem[0] = 5; samp_mem[1] = 6; samp_mem[2] = 7; samp_mem[3] = 8;
        bias_mem[0] = 100;
        run_jobs(4'b0001, 1, 1'b1);
        check("t1_value", res_data_o, 64'd42);

        clear_mems();
        coef_mem[0] = -3;
        samp_mem[0] = 7;
        run_jobs(4'b0001, 1, 1'b0);
        check("t2_neg_shift", res_data_o, 64'hFFFF_FFFF_FFFF_FFFA);

        rand_mems();
        run_jobs(4'b0011, 4, 1'b0);
        rand_mems();
        run_jobs(4'b1111, 5, 1'b0);

        // abort in RUN tap 2
        req_i = 4'b0100;
        repeat (4) tick();
        check("abort_in_run", 64'(mac_op_o), 64'(OP_MAC));
        rst_i = 1'b1;
        req_i = '0;
        tick();
        check("abort_idle", 64'({busy_o, res_valid_o, ack_o}), 64'd0);
        rst_i = 1'b0;
        ptr_m = 0;
        strobes = 0;
        for (int i = 0; i < 2*JOB_LEN; i++) begin
            tick();
            if (res_valid_o || ack_o != '0) strobes++;
        end
        check("abort_no_strobe", 64'(strobes), 64'd0);
        run_jobs(4'b1010, 1, 1'b0);

        for (int k = 0; k < N_TAPS; k++) coef_mem[k] = 32'h7FFF_FFFF;
        for (int k = 0; k < N_CH*N_TAPS; k++) samp_mem[k] = 32'h7FFF_FFFF;
        for (int c = 0; c < N_CH; c++) bias_mem[c] = 64'h7FFF_FFFF_FFFF_FFFF;
        run_jobs(4'b1111, 4, 1'b0);

        for (int it = 0; it < 12; it++) begin
            rand_mems();
            run_jobs(N_CH'($urandom_range(1, 15)), int'($urandom_range(1, 5)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
